// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP slice.
//   tap_state_e        : 4-bit IEEE 1149.1 TAP state, encoding visible on tap_state
//   tap_action_e       : 2-bit action decoded from the current state
//   IR_CAPTURE_PATTERN : value loaded into IR bits [1:0] in Capture-IR
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_TLR      = 4'h0,
    TAP_RTI      = 4'h1,
    TAP_SEL_DR   = 4'h2,
    TAP_SEL_IR   = 4'h3,
    TAP_CAP_DR   = 4'h4,
    TAP_SH_DR    = 4'h5,
    TAP_EX1_DR   = 4'h6,
    TAP_PAUSE_DR = 4'h7,
    TAP_EX2_DR   = 4'h8,
    TAP_UPD_DR   = 4'h9,
    TAP_CAP_IR   = 4'hA,
    TAP_SH_IR    = 4'hB,
    TAP_EX1_IR   = 4'hC,
    TAP_PAUSE_IR = 4'hD,
    TAP_EX2_IR   = 4'hE,
    TAP_UPD_IR   = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    ACT_NONE    = 2'd0,
    ACT_CAPTURE = 2'd1,
    ACT_SHIFT   = 2'd2,
    ACT_UPDATE  = 2'd3
  } tap_action_e;

  localparam logic [1:0] IR_CAPTURE_PATTERN = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register, next-state logic and decode of the
// current state into IR/DR actions.
// Ports:
//   jtag_tck, jtag_tck__enable : clock and clock enable (state holds when low)
//   reset_n                    : asynchronous active-low reset to TLR
//   tms                        : TMS pin
//   ntrst                      : synchronous TAP reset (active low), wins over TMS
//   state                      : current TAP state (also the debug view)
//   ir_action, dr_action       : action for the edge leaving the current state
//   in_tlr                     : current state is Test-Logic-Reset
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic        jtag_tck,
  input  logic        jtag_tck__enable,
  input  logic        reset_n,
  input  logic        tms,
  input  logic        ntrst,
  output tap_state_e  state,
  output tap_action_e ir_action,
  output tap_action_e dr_action,
  output logic        in_tlr
);

  always_ff @(posedge jtag_tck or negedge reset_n) begin
    if (!reset_n) begin
      state <= TAP_TLR;
    end else if (jtag_tck__enable) begin
      if (!ntrst) begin
        state <= TAP_TLR;
      end else begin
        case (state)
          TAP_TLR:      state <= tms ? TAP_TLR      : TAP_RTI;
          TAP_RTI:      state <= tms ? TAP_SEL_DR   : TAP_RTI;
          TAP_SEL_DR:   state <= tms ? TAP_SEL_IR   : TAP_CAP_DR;
          TAP_SEL_IR:   state <= tms ? TAP_TLR      : TAP_CAP_IR;
          TAP_CAP_DR:   state <= tms ? TAP_EX1_DR   : TAP_SH_DR;
          TAP_SH_DR:    state <= tms ? TAP_EX1_DR   : TAP_SH_DR;
          TAP_EX1_DR:   state <= tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
          TAP_PAUSE_DR: state <= tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
          TAP_EX2_DR:   state <= tms ? TAP_UPD_DR   : TAP_SH_DR;
          TAP_UPD_DR:   state <= tms ? TAP_SEL_DR   : TAP_RTI;
          TAP_CAP_IR:   state <= tms ? TAP_EX1_IR   : TAP_SH_IR;
          TAP_SH_IR:    state <= tms ? TAP_EX1_IR   : TAP_SH_IR;
          TAP_EX1_IR:   state <= tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
          TAP_PAUSE_IR: state <= tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
          TAP_EX2_IR:   state <= tms ? TAP_UPD_IR   : TAP_SH_IR;
          TAP_UPD_IR:   state <= tms ? TAP_SEL_DR   : TAP_RTI;
          default:      state <= TAP_TLR;
        endcase
      end
    end
  end

  always_comb begin
    ir_action = ACT_NONE;
    dr_action = ACT_NONE;
    in_tlr    = 1'b0;
    case (state)
      TAP_TLR:    in_tlr    = 1'b1;
      TAP_CAP_IR: ir_action = ACT_CAPTURE;
      TAP_SH_IR:  ir_action = ACT_SHIFT;
      TAP_UPD_IR: ir_action = ACT_UPDATE;
      TAP_CAP_DR: dr_action = ACT_CAPTURE;
      TAP_SH_DR:  dr_action = ACT_SHIFT;
      TAP_UPD_DR: dr_action = ACT_UPDATE;
      default: ;
    endcase
  end

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised JTAG TAP with a built-in IR/DR shift register, BYPASS and IDCODE.
// Ports:
//   jtag_tck, jtag_tck__enable : TCK and its clock enable (everything holds when low)
//   reset_n                    : asynchronous active-low reset
//   jtag__tms, jtag__tdi       : JTAG pins
//   jtag__ntrst                : synchronous TAP reset, active low
//   dr_out, dr_length          : client capture data and DR length for the current IR
//   dr_in                      : shift register contents, for the client on update
//   dr_action                  : 0 none, 1 capture, 2 shift, 3 update (0 for BYPASS/IDCODE)
//   ir, tap_state, tdo         : current instruction, TAP state, serial out (sr[0])
//
// Client protocol: dr_action is a one-shot strobe per enabled TCK edge.
// On capture the TAP samples dr_out at the edge; dr_length must stay stable
// from capture through update; on update the client samples dr_in at the edge.
// There is no back-pressure: the client must always accept.
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int                   IR_WIDTH     = 5,
  parameter int                   DR_WIDTH     = 50,
  parameter logic [IR_WIDTH-1:0]  IR_IDCODE    = IR_WIDTH'(1),
  parameter logic [31:0]          IDCODE_VALUE = 32'h0000_0001
) (
  input  logic                              jtag_tck,
  input  logic                              jtag_tck__enable,
  input  logic                              reset_n,
  input  logic                              jtag__tms,
  input  logic                              jtag__tdi,
  input  logic                              jtag__ntrst,
  input  logic [DR_WIDTH-1:0]               dr_out,
  input  logic [$clog2(DR_WIDTH+1)-1:0]     dr_length,
  output logic [DR_WIDTH-1:0]               dr_in,
  output logic [1:0]                        dr_action,
  output logic [IR_WIDTH-1:0]               ir,
  output logic [3:0]                        tap_state,
  output logic                              tdo
);

  localparam int LEN_W = $clog2(DR_WIDTH+1);
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_IDCODE = LEN_W'(32);
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(DR_WIDTH);

  tap_state_e  state;
  tap_action_e ir_act;
  tap_action_e dr_act;
  logic        in_tlr;

  jtag_tap_fsm u_fsm (
    .jtag_tck         (jtag_tck),
    .jtag_tck__enable (jtag_tck__enable),
    .reset_n          (reset_n),
    .tms              (jtag__tms),
    .ntrst            (jtag__ntrst),
    .state            (state),
    .ir_action        (ir_act),
    .dr_action        (dr_act),
    .in_tlr           (in_tlr)
  );

  logic [DR_WIDTH-1:0] sr;
  logic [DR_WIDTH-1:0] sr_down;
  logic [DR_WIDTH-1:0] ir_shift_next;
  logic [DR_WIDTH-1:0] dr_shift_next;
  logic [DR_WIDTH-1:0] dr_capture;
  logic [LEN_W-1:0]    len;
  logic                is_bypass;
  logic                is_idcode;

  // BYPASS takes priority should IR_IDCODE ever be all ones.
  assign is_bypass = &ir;
  assign is_idcode = (ir == IR_IDCODE) && !is_bypass;

  always_comb begin
    if (is_bypass)                len = LEN_ONE;
    else if (is_idcode)           len = LEN_IDCODE;
    else if (dr_length == '0)     len = LEN_ONE;
    else if (dr_length > LEN_MAX) len = LEN_MAX;
    else                          len = dr_length;
  end

  assign sr_down = sr >> 1;

  // DR shift: TDI enters at bit len-1, everything at len and above is cleared.
  always_comb begin
    dr_shift_next = '0;
    for (int i = 0; i < DR_WIDTH; i++) begin
      if (i < int'(len) - 1)       dr_shift_next[i] = sr_down[i];
      else if (i == int'(len) - 1) dr_shift_next[i] = jtag__tdi;
    end
  end

  always_comb begin
    ir_shift_next = '0;
    ir_shift_next[IR_WIDTH-1:0] = {jtag__tdi, sr_down[IR_WIDTH-2:0]};
  end

  always_comb begin
    if (is_bypass)      dr_capture = '0;
    else if (is_idcode) dr_capture = DR_WIDTH'(IDCODE_VALUE);
    else                dr_capture = dr_out;
  end

  always_ff @(posedge jtag_tck or negedge reset_n) begin
    if (!reset_n) begin
      ir <= IR_IDCODE;
      sr <= '0;
    end else if (jtag_tck__enable) begin
      if (in_tlr) ir <= IR_IDCODE;
      case (ir_act)
        ACT_CAPTURE: sr <= DR_WIDTH'(IR_CAPTURE_PATTERN);
        ACT_SHIFT:   sr <= ir_shift_next;
        ACT_UPDATE:  ir <= sr[IR_WIDTH-1:0];
        default: ;
      endcase
      case (dr_act)
        ACT_CAPTURE: sr <= dr_capture;
        ACT_SHIFT:   sr <= dr_shift_next;
        default: ;
      endcase
    end
  end

  assign dr_in     = sr;
  assign tdo       = sr[0];
  assign tap_state = state;
  assign dr_action = (is_bypass || is_idcode) ? ACT_NONE : dr_act;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Bench for jtag_tap_param: directed scans plus randomized pin activity,
// checked against a table-driven TAP reference model.
module tb_jtag_tap_param;

  localparam int IRW = 5;
  localparam int DRW = 50;
  localparam int LW  = 6;

  logic           jtag_tck = 1'b0;
  logic           jtag_tck__enable;
  logic           reset_n;
  logic           jtag__tms;
  logic           jtag__tdi;
  logic           jtag__ntrst;
  logic [DRW-1:0] dr_out;
  logic [LW-1:0]  dr_length;
  logic [DRW-1:0] dr_in;
  logic [1:0]     dr_action;
  logic [IRW-1:0] ir;
  logic [3:0]     tap_state;
  logic           tdo;

  jtag_tap_param #(
    .IR_WIDTH     (IRW),
    .DR_WIDTH     (DRW),
    .IR_IDCODE    (5'h01),
    .IDCODE_VALUE (32'h0000_0001)
  ) dut (
    .jtag_tck         (jtag_tck),
    .jtag_tck__enable (jtag_tck__enable),
    .reset_n          (reset_n),
    .jtag__tms        (jtag__tms),
    .jtag__tdi        (jtag__tdi),
    .jtag__ntrst      (jtag__ntrst),
    .dr_out           (dr_out),
    .dr_length        (dr_length),
    .dr_in            (dr_in),
    .dr_action        (dr_action),
    .ir               (ir),
    .tap_state        (tap_state),
    .tdo              (tdo)
  );

  // clock / reset
  always #5 jtag_tck = ~jtag_tck;

  int n_cmp = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  // reference model: state numbers, next state from a [state][tms] table
  int             m_state;
  logic [IRW-1:0] m_ir;
  logic [63:0]    m_sr;
  int nxt [16][2] = '{
    '{1, 0},  '{1, 2},  '{4, 3},   '{10, 0},
    '{5, 6},  '{5, 6},  '{7, 9},   '{7, 8},
    '{5, 9},  '{1, 2},  '{11, 12}, '{11, 12},
    '{13, 15},'{13, 14},'{11, 15}, '{1, 2}
  };

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_builtin();
    return (&m_ir) || (m_ir == 5'h01);
  endfunction

  function automatic int m_len();
    if (&m_ir)           return 1;
    if (m_ir == 5'h01)   return 32;
    if (dr_length == 0)  return 1;
    if (dr_length > DRW) return DRW;
    return int'(dr_length);
  endfunction

  function automatic logic [1:0] m_action();
    if (m_builtin()) return 2'd0;
    case (m_state)
      4:       return 2'd1;
      5:       return 2'd2;
      9:       return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_ir    = 5'h01;
    m_sr    = '0;
  endtask

  task automatic model_step();
    int l;
    case (m_state)
      0:  m_ir = 5'h01;
      4: begin
        if (&m_ir)              m_sr = '0;
        else if (m_ir == 5'h01) m_sr = 64'h1;
        else                    m_sr = 64'(dr_out);
      end
      5: begin
        l = m_len();
        m_sr = m_sr >> 1;
        m_sr[l-1] = jtag__tdi;
        m_sr = m_sr & ((64'd1 << l) - 64'd1);
      end
      10: m_sr = 64'h1;
      11: m_sr = ((m_sr >> 1) | (64'(jtag__tdi) << (IRW-1))) & ((64'd1 << IRW) - 64'd1);
      15: m_ir = m_sr[IRW-1:0];
      default: ;
    endcase
    m_state = jtag__ntrst ? nxt[m_state][jtag__tms] : 0;
  endtask

  task automatic compare_all();
    check_eq("tap_state", 64'(tap_state), 64'(m_state));
    check_eq("ir", 64'(ir), 64'(m_ir));
    check_eq("tdo", 64'(tdo), 64'(m_sr[0]));
    check_eq("dr_in", 64'(dr_in), 64'(m_sr[DRW-1:0]));
    check_eq("dr_action", 64'(dr_action), 64'(m_action()));
  endtask

  // driver: one TCK period, inputs driven after the falling edge
  task automatic tick(input logic t_tms, input logic t_tdi);
    jtag__tms = t_tms;
    jtag__tdi = t_tdi;
    @(posedge jtag_tck);
    if (reset_n && jtag_tck__enable) model_step();
    @(negedge jtag_tck);
    compare_all();
  endtask

  // RTI -> full DR scan of n bits -> RTI
  task automatic scan_dr(input int n, input logic [63:0] tdi_bits, input logic [63:0] exp_tdo,
                         input logic [1:0] exp_upd_act, input logic [63:0] exp_dr_in);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("enter_shdr", 64'(tap_state), 64'd5);
    for (int k = 0; k < n; k++) exp_q.push_back(exp_tdo[k]);
    for (int k = 0; k < n; k++) begin
      check_eq("scan_tdo", 64'(tdo), 64'(exp_q.pop_front()));
      tick(k == n - 1, tdi_bits[k]);
    end
    tick(1'b1, 1'b0);
    check_eq("upd_state", 64'(tap_state), 64'd9);
    check_eq("upd_action", 64'(dr_action), 64'(exp_upd_act));
    check_eq("upd_dr_in", 64'(dr_in), exp_dr_in);
    tick(1'b0, 1'b0);
  endtask

  // RTI -> IR scan loading value -> RTI
  task automatic scan_ir(input logic [IRW-1:0] value);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("enter_shir", 64'(tap_state), 64'd11);
    for (int k = 0; k < IRW; k++) begin
      check_eq("ir_capture_tdo", 64'(tdo), (k == 0) ? 64'd1 : 64'd0);
      tick(k == IRW - 1, value[k]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("ir_loaded", 64'(ir), 64'(value));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"}, 64'(tap_state), 64'd0);
    check_eq({tag, "_ir"}, 64'(ir), 64'h01);
    check_eq({tag, "_tdo"}, 64'(tdo), 64'd0);
    check_eq({tag, "_dr_in"}, 64'(dr_in), 64'd0);
    check_eq({tag, "_action"}, 64'(dr_action), 64'd0);
  endtask

  initial begin
    logic [63:0] r;
    reset_n          = 1'b0;
    jtag_tck__enable = 1'b1;
    jtag__ntrst      = 1'b1;
    jtag__tms        = 1'b1;
    jtag__tdi        = 1'b0;
    dr_out           = '0;
    dr_length        = '0;
    model_reset();
    repeat (2) @(negedge jtag_tck);
    check_reset_values("reset");
    reset_n = 1'b1;
    tick(1'b0, 1'b0);

    // IDCODE is the default instruction
    r = {$urandom(), $urandom()};
    scan_dr(32, r, 64'h0000_0001, 2'd0, {32'h0, r[31:0]});

    // BYPASS: one-cycle delay
    scan_ir(5'h1F);
    scan_dr(3, 64'b101, 64'b010, 2'd0, 64'h1);

    // client DR at full width
    scan_ir(5'h10);
    dr_out    = 50'h3_FFFF_0000_1234;
    dr_length = 6'd50;
    scan_dr(50, 64'h1_2345_6789_ABCD, 64'h3_FFFF_0000_1234, 2'd3, 64'h1_2345_6789_ABCD);

    // short client DR
    dr_length = 6'd7;
    dr_out    = 50'h55;
    scan_dr(7, 64'h2A, 64'h55, 2'd3, 64'h2A);

    // length 0 behaves as 1
    dr_length = 6'd0;
    dr_out    = 50'h3;
    scan_dr(2, 64'b10, 64'b01, 2'd3, 64'h1);

    // length above DR_WIDTH clamps to DR_WIDTH
    dr_length = 6'd63;
    r = {$urandom(), $urandom()};
    dr_out = r[DRW-1:0];
    r = {$urandom(), $urandom()};
    scan_dr(50, r, 64'(dr_out), 2'd3, 64'(r[DRW-1:0]));

    // five TMS=1 edges from Shift-IR reach TLR; TLR restores IDCODE
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("five_tms_start", 64'(tap_state), 64'd11);
    repeat (5) tick(1'b1, 1'b0);
    check_eq("five_tms_tlr", 64'(tap_state), 64'd0);
    tick(1'b1, 1'b0);
    check_eq("tlr_ir", 64'(ir), 64'h01);

    // ntrst mid Shift-DR
    tick(1'b0, 1'b0);
    scan_ir(5'h10);
    dr_length = 6'd50;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    jtag__ntrst = 1'b0;
    tick(1'b0, 1'b0);
    jtag__ntrst = 1'b1;
    check_eq("ntrst_tlr", 64'(tap_state), 64'd0);
    tick(1'b1, 1'b0);
    check_eq("ntrst_ir", 64'(ir), 64'h01);

    // clock enable low holds everything
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("en_start", 64'(tap_state), 64'd5);
    jtag_tck__enable = 1'b0;
    repeat (10) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check_eq("en_hold_state", 64'(tap_state), 64'd5);
    jtag_tck__enable = 1'b1;

    // asynchronous reset mid-scan
    tick(1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge jtag_tck);
    reset_n = 1'b1;

    // randomized pin activity
    for (int c = 0; c < 1500; c++) begin
      if (c % 40 == 0) begin
        r = {$urandom(), $urandom()};
        dr_out    = r[DRW-1:0];
        dr_length = 6'($urandom_range(0, 63));
      end
      jtag__ntrst      = ($urandom_range(0, 31) != 0);
      jtag_tck__enable = ($urandom_range(0, 7) != 0);
      tick($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
    end
    jtag__ntrst      = 1'b1;
    jtag_tck__enable = 1'b1;

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_tap_param.md
# jtag_tap_param

- Parametrised second-generation JTAG TAP controller.
- Implements the IEEE 1149.1 16-state FSM, a configurable-width IR and a configurable-width DR shift register that the TAP shifts itself, using a client-supplied length.
- BYPASS and IDCODE are built in and handled without the client.
- Sits between the JTAG pins and debug clients (e.g. a debug module); clients only supply capture data and length, and consume update data.

## Interface
Parameters:
- IR_WIDTH, 5, instruction register width (≥2)
- DR_WIDTH, 50, maximum DR length in bits (≥32)
- IR_IDCODE, 1, instruction loaded in Test-Logic-Reset; selects the built-in IDCODE DR
- IDCODE_VALUE, 32'h0000_0001, built-in IDCODE (bit 0 must be 1)

Ports:
- jtag_tck  input  1  JTAG TCK; the single clock, all flops on posedge
- jtag_tck__enable  input  1  clock enable; no state changes when low
- reset_n  input  1  asynchronous, active-low reset
- jtag__tms  input  1  TMS
- jtag__tdi  input  1  TDI
- jtag__ntrst  input  1  synchronous TAP reset, active low (sampled on enabled edges)
- dr_out  input  DR_WIDTH  client capture data
- dr_length  input  $clog2(DR_WIDTH+1)  client DR length for the current IR
- dr_in  output  DR_WIDTH  shift register contents; valid for the client while dr_action==update
- dr_action  output  2  0 none, 1 capture, 2 shift, 3 update; forced to 0 for BYPASS/IDCODE
- ir  output  IR_WIDTH  current instruction
- tap_state  output  4  current FSM state
- tdo  output  1  sr[0]

## Operation
State encoding:
- 0 TLR, 1 RTI, 2 SelDR, 3 SelIR
- 4 CapDR, 5 ShDR, 6 Ex1DR, 7 PauseDR, 8 Ex2DR, 9 UpdDR
- A CapIR, B ShIR, C Ex1IR, D PauseIR, E Ex2IR, F UpdIR

Transitions (standard 1149.1):
- TMS=1 from SelIR → TLR.
- UpdDR/UpdIR → SelDR on TMS=1, RTI on TMS=0.
- jtag__ntrst=0 on an enabled edge forces next state TLR, overriding TMS.

Actions are decoded from the current state and applied on the enabled edge leaving it:
- **TLR:** ir ← IR_IDCODE.
- **CapIR:** sr ← 0 with sr[1:0] ← 2'b01.
- **ShIR:** sr[IR_WIDTH-1:0] ← {tdi, sr[IR_WIDTH-1:1]}; upper bits are zeroed.
- **UpdIR:** ir ← sr[IR_WIDTH-1:0].

DR length L:
- BYPASS (ir all ones): L = 1.
- IDCODE: L = 32.
- Otherwise: L = dr_length, with 0 treated as 1 and values above DR_WIDTH clamped to DR_WIDTH.

DR actions:
- **CapDR:** sr ← 0 (BYPASS), IDCODE_VALUE zero-extended (IDCODE), else dr_out.
- **ShDR:** sr ← sr>>1 with sr[L-1] ← tdi; bits at L and above are zeroed.
- **UpdDR:** no sr change; the client samples dr_in while dr_action==3.

Other rules:
- Pause and Exit states hold sr and ir.
- dr_length is sampled every ShDR cycle; the client must hold it stable from CapDR to UpdDR.

## Timing
- Reset (reset_n low): state=TLR, ir=IR_IDCODE, sr=0. Outputs: tdo=0, dr_in=0, dr_action=0, tap_state=0.
- dr_action, tdo and tap_state are combinational from registered state; no additional latency.
- Capture data is visible on tdo in the ShDR cycle immediately after CapDR.
- An L-bit scan needs exactly L ShDR edges: bit k of the capture value appears on tdo in the (k+1)-th ShDR cycle.
- Five TMS=1 enabled edges reach TLR from any state.
- jtag__tck__enable low: everything holds, including over TMS/TDI changes.
- jtag__ntrst low during ShDR: next edge → TLR, ir=IR_IDCODE; sr is not cleared.
- reset_n asserted mid-scan: immediate return to reset values.

## Structure
- Shared package jtag_pkg holds:
  - the 4-bit TAP state enum (encoding above)
  - the 2-bit action enum (none/capture/shift/update)
  - the IR_CAPTURE_PATTERN constant 2'b01
- One natural sub-module, jtag_tap_fsm: the state register, next-state logic and state decode into ir/dr actions.
- The IR/DR datapath and length/mask generation stay in the top.

## Test plan
- Reset, then shift 32 bits of DR with ir=IDCODE (default) → tdo serialises 32'h0000_0001 LSB first; dr_action stays 0 throughout.
- Shift-IR 5'b11111, then a DR scan with TDI pattern 1,0,1 → tdo is 0,1,0 (one-cycle bypass delay).
- Set ir=5'h10, dr_out=50'h3_FFFF_0000_1234, dr_length=50, shift 50 bits of TDI=50'h1_2345_6789_ABCD → tdo returns dr_out LSB first; dr_in=50'h1_2345_6789_ABCD during UpdDR (dr_action=3).
- Same IR with dr_length=7, dr_out=7'h55, shift 7 bits of 7'h2A → dr_in=50'h2A; bits at position 7 and above are 0.
- During a Shift-IR, check capture/TMS handling:
  - TDO gives 1,0,0,0,0 (capture pattern).
  - Five TMS=1 edges → TLR, ir=IR_IDCODE.
  - jtag__ntrst low for one edge mid-ShDR → TLR.
  - jtag_tck__enable low for 10 cycles → no state change.
